// File: rtl/aig_mix_pkg.sv
// aig_mix_pkg: shared widths and pipeline stage record for the mix datapath scheduler.
package aig_mix_pkg;
  localparam int AIG_IN_W  = 80;
  localparam int AIG_OUT_W = 40;
  localparam int AIG_TAG_W = 4;
  localparam int AIG_SRC_W = 3;
  typedef struct packed {
    logic                 vld;
    logic [AIG_IN_W-1:0]  data;
    logic [AIG_SRC_W-1:0] src;
    logic [AIG_TAG_W-1:0] tag;
  } aig_stage_t;
endpackage

// File: rtl/aig_rr_pick.sv
// aig_rr_pick: combinational round-robin pick, first valid requester at or after ptr wins.
module aig_rr_pick #(
  parameter int NREQ = 4,
  localparam int SW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [SW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [SW-1:0]   idx,
  output logic            any
);
  // Scan farthest offset first so the nearest valid requester overwrites last.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NREQ]) begin
        idx = SW'((int'(ptr) + k) % NREQ);
        any = 1'b1;
      end
    gnt[idx] = any;
  end
endmodule

// File: rtl/aig_mix_sched.sv
// aig_mix_sched: round-robin scheduler sharing one combinational mix datapath among NREQ requesters
// through a two-stage operand/result pipeline.
module aig_mix_sched import aig_mix_pkg::*; #(
  parameter int NREQ  = 4,
  parameter int IN_W  = AIG_IN_W,
  parameter int OUT_W = AIG_OUT_W,
  parameter int TAG_W = AIG_TAG_W,
  localparam int SW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*IN_W-1:0]  req_data,
  input  logic [NREQ*TAG_W-1:0] req_tag,
  output logic [IN_W-1:0]       core_in,
  input  logic [OUT_W-1:0]      core_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [OUT_W-1:0]      rsp_data,
  output logic [SW-1:0]         rsp_src,
  output logic [TAG_W-1:0]      rsp_tag,
  output logic                  busy,
  output logic [15:0]           done_cnt
);
  aig_stage_t a_q, a_d;
  logic [SW-1:0] ptr_q, ptr_d, idx, b_src_q, b_src_d;
  logic [OUT_W-1:0] b_data_q, b_data_d;
  logic [TAG_W-1:0] b_tag_q, b_tag_d;
  logic [15:0] done_cnt_q, done_cnt_d;
  logic [NREQ-1:0] gnt;
  logic b_vld_q, b_vld_d, any, adv_a, adv_b, grant;

  aig_rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );

  // A frees up whenever it is empty or hands its operand to B this cycle.
  always_comb begin
    adv_b      = a_q.vld & (~b_vld_q | rsp_ready);
    adv_a      = ~a_q.vld | adv_b;
    grant      = en & adv_a & any;
    req_ready  = grant ? gnt : '0;
    ptr_d      = grant ? ((idx == SW'(NREQ - 1)) ? '0 : idx + 1'b1) : ptr_q;
    a_d        = a_q;
    a_d.vld    = adv_a ? grant : a_q.vld;
    if (grant) begin
      a_d.data = AIG_IN_W'(req_data[idx*IN_W +: IN_W]);
      a_d.src  = AIG_SRC_W'(idx);
      a_d.tag  = AIG_TAG_W'(req_tag[idx*TAG_W +: TAG_W]);
    end
    b_vld_d    = adv_b | (b_vld_q & ~rsp_ready);
    b_data_d   = adv_b ? core_out : b_data_q;
    b_src_d    = adv_b ? a_q.src[SW-1:0] : b_src_q;
    b_tag_d    = adv_b ? a_q.tag[TAG_W-1:0] : b_tag_q;
    done_cnt_d = (b_vld_q & rsp_ready & ~&done_cnt_q) ? done_cnt_q + 16'd1 : done_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q        <= '0;
      ptr_q      <= '0;
      b_vld_q    <= 1'b0;
      b_data_q   <= '0;
      b_src_q    <= '0;
      b_tag_q    <= '0;
      done_cnt_q <= '0;
    end else begin
      a_q        <= a_d;
      ptr_q      <= ptr_d;
      b_vld_q    <= b_vld_d;
      b_data_q   <= b_data_d;
      b_src_q    <= b_src_d;
      b_tag_q    <= b_tag_d;
      done_cnt_q <= done_cnt_d;
    end

  assign core_in   = a_q.data[IN_W-1:0];
  assign rsp_valid = b_vld_q;
  assign rsp_data  = b_data_q;
  assign rsp_src   = b_src_q;
  assign rsp_tag   = b_tag_q;
  assign busy      = a_q.vld | b_vld_q;
  assign done_cnt  = done_cnt_q;
endmodule

// File: tb/tb_aig_mix_sched.sv
// tb_aig_mix_sched: directed scenarios for the scheduler with a stand-in mix core on core_in/core_out.
module tb_aig_mix_sched;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, rsp_ready = 1'b0;
  logic [3:0] req_valid = '0, req_ready;
  logic [319:0] req_data = '0;
  logic [15:0] req_tag = '0;
  logic [79:0] core_in;
  logic [39:0] core_out, rsp_data;
  logic rsp_valid, busy;
  logic [1:0] rsp_src;
  logic [3:0] rsp_tag;
  logic [15:0] done_cnt;
  logic [79:0] dv [4];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  function automatic logic [39:0] mix(input logic [79:0] x);
    return x[39:0] ^ x[79:40] ^ 40'h2882882882;
  endfunction

  assign core_out = mix(core_in);

  aig_mix_sched dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_tag(req_tag), .core_in(core_in), .core_out(core_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_src(rsp_src),
    .rsp_tag(rsp_tag), .busy(busy), .done_cnt(done_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_all();
    for (int i = 0; i < 4; i++) begin
      req_data[i*80 +: 80] = dv[i];
      req_tag[i*4 +: 4] = 4'(i + 8);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    tick();
    checks++;
    if ({rsp_valid, busy, req_ready, done_cnt} !== 22'd0) begin
      errors++;
      $display("FAIL reset_ctl got v=%b busy=%b rdy=%b cnt=%0d want 0", rsp_valid, busy, req_ready, done_cnt);
    end
    checks++;
    if ({core_in, rsp_data, rsp_src, rsp_tag} !== 126'd0) begin
      errors++;
      $display("FAIL reset_data got core_in=%h rsp=%h src=%0d tag=%h want 0", core_in, rsp_data, rsp_src, rsp_tag);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    en = 1'b1; rsp_ready = 1'b1;
    req_data[79:0] = '0; req_tag[3:0] = 4'h5; req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    checks++;
    if (core_in !== 80'd0 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL single_stageA got core_in=%h v=%b busy=%b want 0/0/1", core_in, rsp_valid, busy);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 40'h2882882882 || rsp_src !== 2'd0 || rsp_tag !== 4'h5) begin
      errors++; $display("FAIL single_rsp got v=%b d=%h src=%0d tag=%h want 1/2882882882/0/5", rsp_valid, rsp_data, rsp_src, rsp_tag);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || done_cnt !== 16'd1) begin
      errors++; $display("FAIL single_done got v=%b busy=%b cnt=%0d want 0/0/1", rsp_valid, busy, done_cnt);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    load_all();
    en = 1'b1; rsp_ready = 1'b1; req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if (req_ready !== 4'(1 << (c % 4))) begin
        errors++; $display("FAIL rr_grant c=%0d got %b want %b", c, req_ready, 4'(1 << (c % 4)));
      end
      tick();
      if (c >= 1) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_src !== 2'((c - 1) % 4) || rsp_data !== mix(dv[(c - 1) % 4]) || rsp_tag !== 4'(((c - 1) % 4) + 8)) begin
          errors++; $display("FAIL rr_rsp c=%0d got v=%b src=%0d d=%h tag=%h want src=%0d", c, rsp_valid, rsp_src, rsp_data, rsp_tag, (c - 1) % 4);
        end
      end
    end
    req_valid = '0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_src !== 2'd3 || done_cnt !== 16'd7) begin
      errors++; $display("FAIL rr_tail got v=%b src=%0d cnt=%0d want 1/3/7", rsp_valid, rsp_src, done_cnt);
    end
  endtask

  task automatic test_stall();
    do_reset();
    load_all();
    en = 1'b1; rsp_ready = 1'b0; req_valid = 4'hF;
    tick();
    tick();
    checks++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_src !== 2'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL stall_full got rdy=%b v=%b src=%0d busy=%b want 0000/1/0/1", req_ready, rsp_valid, rsp_src, busy);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_src !== 2'd0 || rsp_data !== mix(dv[0]) || rsp_tag !== 4'd8) begin
        errors++; $display("FAIL stall_hold c=%0d got rdy=%b v=%b src=%0d d=%h tag=%h", c, req_ready, rsp_valid, rsp_src, rsp_data, rsp_tag);
      end
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL stall_release_grant got %b want 0100", req_ready); end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_src !== 2'd1 || rsp_data !== mix(dv[1]) || req_ready !== 4'b1000 || done_cnt !== 16'd1) begin
      errors++; $display("FAIL stall_b2b got v=%b src=%0d rdy=%b cnt=%0d want 1/1/1000/1", rsp_valid, rsp_src, req_ready, done_cnt);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_src !== 2'd2 || done_cnt !== 16'd2) begin
      errors++; $display("FAIL stall_resume got v=%b src=%0d cnt=%0d want 1/2/2", rsp_valid, rsp_src, done_cnt);
    end
  endtask

  task automatic test_enable();
    do_reset();
    load_all();
    en = 1'b1; rsp_ready = 1'b1; req_valid = 4'hF;
    tick();
    en = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0000 || busy !== 1'b1) begin
      errors++; $display("FAIL en_block got rdy=%b busy=%b want 0000/1", req_ready, busy);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_src !== 2'd0 || busy !== 1'b1 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL en_drain got v=%b src=%0d busy=%b rdy=%b want 1/0/1/0000", rsp_valid, rsp_src, busy, req_ready);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || done_cnt !== 16'd1) begin
      errors++; $display("FAIL en_idle got busy=%b v=%b cnt=%0d want 0/0/1", busy, rsp_valid, done_cnt);
    end
    en = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL en_ptr got %b want 0010", req_ready); end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0; en = 1'b1; req_valid = 4'hF;
    tick();
    tick();
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b1 || rsp_src !== 2'd1 || done_cnt !== 16'd1) begin
      errors++; $display("FAIL rstmid_pre got busy=%b v=%b src=%0d cnt=%0d want 1/1/1/1", busy, rsp_valid, rsp_src, done_cnt);
    end
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || done_cnt !== 16'd0) begin
      errors++; $display("FAIL rstmid_clear got v=%b busy=%b cnt=%0d want 0/0/0", rsp_valid, busy, done_cnt);
    end
    tick();
    rst_n = 1'b1; rsp_ready = 1'b1; req_valid = 4'hF;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_ptr got %b want 0001", req_ready); end
    tick();
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_src !== 2'd0 || rsp_data !== mix(dv[0])) begin
      errors++; $display("FAIL rstmid_rsp got v=%b src=%0d d=%h want 1/0", rsp_valid, rsp_src, rsp_data);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    load_all();
    en = 1'b1; rsp_ready = 1'b1; req_valid = 4'hF;
    for (int c = 0; c < 65536; c++) tick();
    checks++;
    if (done_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h want FFFE", done_cnt); end
    tick();
    checks++;
    if (done_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_top got %h want FFFF", done_cnt); end
    for (int c = 0; c < 3; c++) tick();
    checks++;
    if (done_cnt !== 16'hFFFF || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL sat_hold got cnt=%h v=%b want FFFF/1", done_cnt, rsp_valid);
    end
  endtask

  initial begin
    dv[0] = 80'h0123456789ABCDEF0011;
    dv[1] = 80'hFEDCBA98765432100022;
    dv[2] = 80'h5A5A5A5A5AA5A5A5A5A5;
    dv[3] = 80'h00000000FFFFFFFFFFFF;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_enable();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
